// File: rtl/ppu_lcd_timing_pkg.sv
// ppu_lcd_timing_pkg: MMIO register addresses, PPU mode encoding and STAT bit positions
package ppu_lcd_timing_pkg;
  localparam logic [15:0] A_LCDC = 16'hFF40;
  localparam logic [15:0] A_STAT = 16'hFF41;
  localparam logic [15:0] A_SCY  = 16'hFF42;
  localparam logic [15:0] A_SCX  = 16'hFF43;
  localparam logic [15:0] A_LY   = 16'hFF44;
  localparam logic [15:0] A_LYC  = 16'hFF45;
  localparam logic [15:0] A_BGP  = 16'hFF47;
  localparam logic [15:0] A_OBP0 = 16'hFF48;
  localparam logic [15:0] A_OBP1 = 16'hFF49;
  localparam logic [15:0] A_WY   = 16'hFF4A;
  localparam logic [15:0] A_WX   = 16'hFF4B;
  typedef enum logic [1:0] {HBLANK = 2'd0, VBLANK = 2'd1, OAM = 2'd2, DRAW = 2'd3} ppu_mode_e;
  localparam int STAT_LYC_IE = 6;
  localparam int STAT_OAM_IE = 5;
  localparam int STAT_VBL_IE = 4;
  localparam int STAT_HBL_IE = 3;
  localparam int STAT_COINC  = 2;
endpackage

// File: rtl/ppu_lcd_timing_if.sv
// ppu_lcd_timing_if: CPU MMIO bus into the LCD register bank
// ADDR/WR/RD/MMIO_DATA_out driven by the CPU side, MMIO_DATA_in returned by the PPU
interface ppu_lcd_timing_if;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  modport master (output ADDR, WR, RD, MMIO_DATA_out, input MMIO_DATA_in);
  modport slave (input ADDR, WR, RD, MMIO_DATA_out, output MMIO_DATA_in);
endinterface

// File: rtl/ppu_lcd_timing_mmio_regs.sv
// ppu_lcd_timing_mmio_regs: LCD register bank with write decode and registered read mux
// in: clk, rst, bus (MMIO slave), ly/mode/coinc for the read-only fields
// out: lcdc, stat_ie (STAT[6:3]), scy, scx, lyc, bgp, obp0, obp1, wy, wx
module ppu_lcd_timing_mmio_regs
  import ppu_lcd_timing_pkg::*;
#(
  parameter logic [7:0] LCDC_RST = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  ppu_lcd_timing_if.slave  bus,
  input  logic [7:0]       ly,
  input  logic [1:0]       mode,
  input  logic             coinc,
  output logic [7:0]       lcdc,
  output logic [3:0]       stat_ie,
  output logic [7:0]       scy,
  output logic [7:0]       scx,
  output logic [7:0]       lyc,
  output logic [7:0]       bgp,
  output logic [7:0]       obp0,
  output logic [7:0]       obp1,
  output logic [7:0]       wy,
  output logic [7:0]       wx
);
  logic [7:0] stat_rd, rd_mux, rdata;
  always_comb begin
    stat_rd = 8'h80;
    stat_rd[STAT_LYC_IE:STAT_HBL_IE] = stat_ie;
    stat_rd[STAT_COINC] = coinc;
    stat_rd[1:0] = mode;
    case (bus.ADDR)
      A_LCDC:  rd_mux = lcdc;
      A_STAT:  rd_mux = stat_rd;
      A_SCY:   rd_mux = scy;
      A_SCX:   rd_mux = scx;
      A_LY:    rd_mux = ly;
      A_LYC:   rd_mux = lyc;
      A_BGP:   rd_mux = bgp;
      A_OBP0:  rd_mux = obp0;
      A_OBP1:  rd_mux = obp1;
      A_WY:    rd_mux = wy;
      A_WX:    rd_mux = wx;
      default: rd_mux = 8'h00;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      lcdc    <= LCDC_RST;
      stat_ie <= '0;
      scy     <= '0;
      scx     <= '0;
      lyc     <= '0;
      bgp     <= 8'hFC;
      obp0    <= '0;
      obp1    <= '0;
      wy      <= '0;
      wx      <= '0;
      rdata   <= '0;
    end else begin
      if (bus.RD) rdata <= rd_mux;
      if (bus.WR)
        case (bus.ADDR)
          A_LCDC:  lcdc    <= bus.MMIO_DATA_out;
          A_STAT:  stat_ie <= bus.MMIO_DATA_out[STAT_LYC_IE:STAT_HBL_IE];
          A_SCY:   scy     <= bus.MMIO_DATA_out;
          A_SCX:   scx     <= bus.MMIO_DATA_out;
          A_LYC:   lyc     <= bus.MMIO_DATA_out;
          A_BGP:   bgp     <= bus.MMIO_DATA_out;
          A_OBP0:  obp0    <= bus.MMIO_DATA_out;
          A_OBP1:  obp1    <= bus.MMIO_DATA_out;
          A_WY:    wy      <= bus.MMIO_DATA_out;
          A_WX:    wx      <= bus.MMIO_DATA_out;
          default: ;
        endcase
    end
  assign bus.MMIO_DATA_in = rdata;
endmodule

// File: rtl/ppu_lcd_timing.sv
// ppu_lcd_timing: LCD dot/line timing, PPU mode sequencing, LY/LYC coincidence and STAT/V-blank interrupts
// in: clk, rst, bus (MMIO slave), draw_done (fetcher end of mode 3)
// out: IRQ_V_BLANK, IRQ_LCDC (one-cycle pulses), PPU_MODE, LY_out, DOT_out, *_q register values
module ppu_lcd_timing
  import ppu_lcd_timing_pkg::*;
#(
  parameter int         H_DOTS        = 456,
  parameter int         V_LINES       = 154,
  parameter int         V_ACTIVE      = 144,
  parameter int         OAM_DOTS      = 80,
  parameter int         MAX_DRAW_DOTS = 289,
  parameter logic [7:0] LCDC_RST      = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  ppu_lcd_timing_if.slave           bus,
  input  logic                      draw_done,
  output logic                      IRQ_V_BLANK,
  output logic                      IRQ_LCDC,
  output logic [1:0]                PPU_MODE,
  output logic [7:0]                LY_out,
  output logic [$clog2(H_DOTS)-1:0] DOT_out,
  output logic [7:0]                LCDC_q,
  output logic [7:0]                SCY_q,
  output logic [7:0]                SCX_q,
  output logic [7:0]                WY_q,
  output logic [7:0]                WX_q,
  output logic [7:0]                BGP_q,
  output logic [7:0]                OBP0_q,
  output logic [7:0]                OBP1_q
);
  localparam int DW = $clog2(H_DOTS);
  localparam logic [1:0] M_HB = HBLANK, M_VB = VBLANK, M_OAM = OAM, M_DR = DRAW;
  logic [3:0] stat_ie;
  logic [7:0] lyc, line_n;
  logic [DW-1:0] dot_n;
  logic [1:0] mode_n;
  logic en_nxt, dot_wrap, coinc, s_line, s_q;
  ppu_lcd_timing_mmio_regs #(.LCDC_RST(LCDC_RST)) u_regs (
    .clk(clk), .rst(rst), .bus(bus), .ly(LY_out), .mode(PPU_MODE), .coinc(coinc),
    .lcdc(LCDC_q), .stat_ie(stat_ie), .scy(SCY_q), .scx(SCX_q), .lyc(lyc),
    .bgp(BGP_q), .obp0(OBP0_q), .obp1(OBP1_q), .wy(WY_q), .wx(WX_q)
  );
  // en_nxt looks at an LCDC write in flight so the counters switch on the same edge LCDC_q does
  always_comb begin
    en_nxt = (bus.WR && bus.ADDR == A_LCDC) ? bus.MMIO_DATA_out[7] : LCDC_q[7];
    dot_wrap = DOT_out == DW'(H_DOTS - 1);
    dot_n = dot_wrap ? '0 : DOT_out + DW'(1);
    line_n = !dot_wrap ? LY_out : LY_out == 8'(V_LINES - 1) ? '0 : LY_out + 8'd1;
    mode_n = line_n >= 8'(V_ACTIVE) ? M_VB :
             dot_n < DW'(OAM_DOTS) ? M_OAM :
             (dot_n == DW'(OAM_DOTS) || (PPU_MODE == M_DR && !draw_done && dot_n < DW'(OAM_DOTS + MAX_DRAW_DOTS))) ? M_DR : M_HB;
    coinc = LY_out == lyc;
    s_line = LCDC_q[7] && ((stat_ie[STAT_LYC_IE-STAT_HBL_IE] && coinc) ||
                           (stat_ie[STAT_OAM_IE-STAT_HBL_IE] && PPU_MODE == M_OAM) ||
                           (stat_ie[STAT_VBL_IE-STAT_HBL_IE] && PPU_MODE == M_VB) ||
                           (stat_ie[0] && PPU_MODE == M_HB));
  end
  always_ff @(posedge clk)
    if (rst || !en_nxt) begin
      DOT_out  <= '0;
      LY_out   <= '0;
      PPU_MODE <= M_HB;
    end else if (!LCDC_q[7]) begin
      DOT_out  <= '0;
      LY_out   <= '0;
      PPU_MODE <= M_OAM;
    end else begin
      DOT_out  <= dot_n;
      LY_out   <= line_n;
      PPU_MODE <= mode_n;
    end
  // s_q remembers the STAT line so only its rising edge interrupts
  always_ff @(posedge clk)
    if (rst) begin
      s_q         <= 1'b0;
      IRQ_LCDC    <= 1'b0;
      IRQ_V_BLANK <= 1'b0;
    end else begin
      s_q         <= s_line;
      IRQ_LCDC    <= s_line && !s_q;
      IRQ_V_BLANK <= LCDC_q[7] && LY_out == 8'(V_ACTIVE) && DOT_out == '0;
    end
endmodule

// File: tb/tb_ppu_lcd_timing.sv
// tb_ppu_lcd_timing: directed stimulus with a frame-position model checked every cycle
module tb_ppu_lcd_timing;
  import ppu_lcd_timing_pkg::*;
  logic clk = 1'b0, rst = 1'b1, draw_done = 1'b0;
  logic iv, il;
  logic [1:0] mode;
  logic [7:0] ly, lcdc, scy, scx, wy, wx, bgp, obp0, obp1;
  logic [8:0] dot;
  int tests = 0, fails = 0, vb_seen = 0, il_seen = 0;
  bit chk_on = 1'b0;
  ppu_lcd_timing_if bus();
  ppu_lcd_timing dut (
    .clk(clk), .rst(rst), .bus(bus), .draw_done(draw_done),
    .IRQ_V_BLANK(iv), .IRQ_LCDC(il), .PPU_MODE(mode), .LY_out(ly), .DOT_out(dot),
    .LCDC_q(lcdc), .SCY_q(scy), .SCX_q(scx), .WY_q(wy), .WX_q(wx),
    .BGP_q(bgp), .OBP0_q(obp0), .OBP1_q(obp1)
  );
  always #5 clk = ~clk;
  logic [7:0] m_r [16];
  int m_pos, m_end3;
  logic [7:0] m_rd;
  bit m_sp, m_il, m_iv;
  function automatic int e_dot();
    return m_r[0][7] ? m_pos % 456 : 0;
  endfunction
  function automatic int e_ly();
    return m_r[0][7] ? (m_pos / 456) % 154 : 0;
  endfunction
  function automatic int e_mode();
    int d = e_dot();
    int l = e_ly();
    if (!m_r[0][7]) return 0;
    if (l >= 144) return 1;
    if (d < 80) return 2;
    return d < m_end3 ? 3 : 0;
  endfunction
  function automatic bit e_coinc();
    return e_ly() == int'(m_r[5]);
  endfunction
  function automatic bit e_s();
    int md = e_mode();
    logic [7:0] st = m_r[1];
    return m_r[0][7] && ((st[6] && e_coinc()) || (st[5] && md == 2) || (st[4] && md == 1) || (st[3] && md == 0));
  endfunction
  function automatic logic [7:0] e_read(input logic [15:0] a);
    if (a < 16'hFF40 || a > 16'hFF4B || a == 16'hFF46) return 8'h00;
    if (a == 16'hFF41) return {1'b1, m_r[1][6:3], e_coinc(), 2'(e_mode())};
    if (a == 16'hFF44) return 8'(e_ly());
    return m_r[a[3:0]];
  endfunction
  always @(posedge clk) begin
    int d, l, md;
    bit s, was;
    d = e_dot();
    l = e_ly();
    md = e_mode();
    s = e_s();
    was = m_r[0][7];
    if (rst) begin
      foreach (m_r[i]) m_r[i] = 8'h00;
      m_r[7] = 8'hFC;
      m_pos = 0;
      m_end3 = 369;
      m_rd = 8'h00;
      m_sp = 1'b0;
      m_il = 1'b0;
      m_iv = 1'b0;
    end else begin
      m_il = s && !m_sp;
      m_sp = s;
      m_iv = was && l == 144 && d == 0;
      if (bus.RD) m_rd = e_read(bus.ADDR);
      if (md == 3 && draw_done) m_end3 = d + 1;
      if (bus.WR && bus.ADDR >= 16'hFF40 && bus.ADDR <= 16'hFF4B && bus.ADDR != 16'hFF44 && bus.ADDR != 16'hFF46)
        m_r[bus.ADDR[3:0]] = bus.ADDR == 16'hFF41 ? bus.MMIO_DATA_out & 8'h78 : bus.MMIO_DATA_out;
      if (m_r[0][7] && !was) begin
        m_pos = 0;
        m_end3 = 369;
      end else if (m_r[0][7]) begin
        m_pos++;
        if (m_pos % 456 == 0) m_end3 = 369;
      end
    end
  end
  always @(negedge clk)
    if (chk_on) begin
      logic [92:0] a, e;
      a = {dot, ly, mode, iv, il, bus.MMIO_DATA_in, lcdc, scy, scx, wy, wx, bgp, obp0, obp1};
      e = {9'(e_dot()), 8'(e_ly()), 2'(e_mode()), m_iv, m_il, m_rd,
           m_r[0], m_r[2], m_r[3], m_r[10], m_r[11], m_r[7], m_r[8], m_r[9]};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model t=%0t got=%h want=%h (dot,ly,mode,iv,il,rd,lcdc,scy,scx,wy,wx,bgp,obp0,obp1)", $time, a, e);
      end
    end
  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      vb_seen += int'(iv);
      il_seen += int'(il);
    end
  endtask
  task automatic wait_pos(input int l, input int d);
    int n = 0;
    while (!(int'(ly) == l && int'(dot) == d) && n < 72000) begin
      tick();
      n++;
    end
    chk($sformatf("reach_ly%0d_dot%0d", l, d), int'(n < 72000), 1);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.ADDR = a;
    bus.MMIO_DATA_out = d;
    bus.WR = 1'b1;
    tick();
    bus.WR = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.ADDR = a;
    bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0;
    d = bus.MMIO_DATA_in;
  endtask
  initial begin
    logic [7:0] r;
    bus.ADDR = 16'h0000;
    bus.WR = 1'b0;
    bus.RD = 1'b0;
    bus.MMIO_DATA_out = 8'h00;
    tick(3);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_lcdc", lcdc, 8'h00);
    chk("reset_bgp", bgp, 8'hFC);
    chk("reset_mode", mode, 0);
    chk("reset_ly", ly, 0);
    chk("reset_irq", {iv, il}, 0);
    rd(16'hFF47, r);
    chk("rd_bgp_reset", r, 8'hFC);
    wr(16'hFF40, 8'h80);
    chk("enable_dot", dot, 0);
    chk("enable_mode", mode, 2);
    wait_pos(0, 79);
    chk("oam_last", mode, 2);
    tick();
    chk("draw_first", mode, 3);
    wait_pos(0, 368);
    chk("draw_last", mode, 3);
    tick();
    chk("hblank_timeout", mode, 0);
    wait_pos(0, 455);
    chk("hblank_end", mode, 0);
    tick();
    chk("line1_ly", ly, 1);
    chk("line1_mode", mode, 2);
    wait_pos(1, 250);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("draw_done_dot", dot, 251);
    chk("draw_done_mode", mode, 0);
    wait_pos(2, 40);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    wait_pos(2, 368);
    chk("draw_done_ignored_in_oam", mode, 3);
    wait_pos(2, 370);
    wr(16'hFF42, 8'h12);
    wr(16'hFF43, 8'h34);
    wr(16'hFF4A, 8'h56);
    wr(16'hFF4B, 8'h78);
    wr(16'hFF47, 8'hE4);
    wr(16'hFF48, 8'hD2);
    wr(16'hFF49, 8'h1B);
    wr(16'hFF45, 8'd10);
    wr(16'hFF41, 8'h40);
    rd(16'hFF42, r);
    chk("rd_scy", r, 8'h12);
    rd(16'hFF49, r);
    chk("rd_obp1", r, 8'h1B);
    rd(16'hFF41, r);
    chk("rd_stat_line2", r, 8'hC0);
    il_seen = 0;
    wait_pos(10, 0);
    chk("lyc_irq_latency0", il, 0);
    tick();
    chk("lyc_irq_pulse", il, 1);
    tick();
    chk("lyc_irq_one_cycle", il, 0);
    rd(16'hFF41, r);
    chk("stat_coinc_line10", r, 8'hC6);
    wait_pos(11, 10);
    rd(16'hFF41, r);
    chk("stat_coinc_line11", r, 8'hC2);
    chk("lyc_irq_count", il_seen, 1);
    wait_pos(50, 10);
    il_seen = 0;
    vb_seen = 0;
    wr(16'hFF40, 8'h00);
    chk("disable_ly", ly, 0);
    chk("disable_mode", mode, 0);
    chk("disable_dot", dot, 0);
    tick(20);
    wr(16'hFF43, 8'hAB);
    rd(16'hFF43, r);
    chk("disabled_scx", r, 8'hAB);
    wr(16'hFF44, 8'h33);
    rd(16'hFF44, r);
    chk("ly_write_ignored", r, 0);
    rd(16'hFF46, r);
    chk("unowned_read", r, 0);
    chk("disabled_irqs", il_seen + vb_seen, 0);
    wr(16'hFF40, 8'h80);
    chk("reenable_dot", dot, 0);
    chk("reenable_ly", ly, 0);
    chk("reenable_mode", mode, 2);
    vb_seen = 0;
    wr(16'hFF45, 8'd5);
    il_seen = 0;
    wait_pos(5, 0);
    chk("blk_pulse_latency0", il, 0);
    tick();
    chk("blk_coinc_pulse", il, 1);
    wait_pos(5, 100);
    wr(16'hFF41, 8'h48);
    wait_pos(5, 369);
    chk("blk_line5_hblank", mode, 0);
    tick();
    chk("blk_line5_no_pulse", il, 0);
    wait_pos(6, 369);
    chk("blk_line6_hblank", mode, 0);
    tick();
    chk("blk_line6_pulse", il, 1);
    chk("blk_pulse_count", il_seen, 2);
    wait_pos(144, 0);
    chk("vblank_mode", mode, 1);
    chk("vblank_latency0", iv, 0);
    tick();
    chk("vblank_pulse", iv, 1);
    wait_pos(153, 455);
    chk("last_line_mode", mode, 1);
    tick();
    chk("wrap_ly", ly, 0);
    chk("wrap_mode", mode, 2);
    chk("vblank_count", vb_seen, 1);
    tick(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_lcdc", lcdc, 8'h00);
    chk("midreset_bgp", bgp, 8'hFC);
    chk("midreset_scx", scx, 0);
    chk("midreset_ly_mode", {ly, mode}, 0);
    chk("midreset_irq", {iv, il}, 0);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ppu_lcd_timing.md
# ppu_lcd_timing

Parametrised LCD timing generator and PPU register bank for the Game Boy graphics path. It owns dot and line counters, mode sequencing (OAM scan, draw, HBlank, VBlank), and the LY/LYC coincidence logic. It produces the V-blank and STAT (LCDC) interrupts with STAT-line edge blocking, and exposes the CPU-visible LCD registers to the pixel pipeline. It sits between the MMIO bus and the pixel fetcher. Mode-3 length is variable, set by a fetcher handshake.

## Interface
- H_DOTS, 456: dots per line
- V_LINES, 154: lines per frame
- V_ACTIVE, 144: visible lines; VBlank is lines V_ACTIVE..V_LINES-1
- OAM_DOTS, 80: mode-2 length
- MAX_DRAW_DOTS, 289: mode-3 timeout; must satisfy OAM_DOTS+MAX_DRAW_DOTS < H_DOTS
- LCDC_RST, 8'h00: LCDC reset value
- clk  in  1  system clock, one dot per cycle
- rst  in  1  synchronous, active-high reset
- ADDR  in  16  CPU MMIO address
- WR  in  1  write strobe
- RD  in  1  read strobe
- MMIO_DATA_out  in  8  CPU write data
- MMIO_DATA_in  out  8  read data
- draw_done  in  1  fetcher pulse that ends mode 3
- IRQ_V_BLANK  out  1  one-cycle pulse
- IRQ_LCDC  out  1  one-cycle pulse
- PPU_MODE  out  2  0 HBlank, 1 VBlank, 2 OAM, 3 draw
- LY_out  out  8  current line
- DOT_out  out  $clog2(H_DOTS)  dot within the line
- LCDC_q, SCY_q, SCX_q, WY_q, WX_q, BGP_q, OBP0_q, OBP1_q  out  8 each  register values to the pixel pipe

## Operation
**Register map** (the DMA register at FF46 is not owned by this block):
- FF40 LCDC
- FF41 STAT: bits[6:3] are read/write; bit2 is the coincidence flag (read-only); bits[1:0] are PPU_MODE (read-only); bit7 reads 1
- FF42 SCY, FF43 SCX
- FF44 LY: read-only; writes are ignored
- FF45 LYC
- FF47 BGP, FF48 OBP0, FF49 OBP1
- FF4A WY, FF4B WX

**Reset values:**
- LCDC = LCDC_RST; BGP = 8'hFC; all other registers 0
- Counters 0; all outputs 0

**Counters:**
- dot increments each cycle and wraps at H_DOTS-1 to 0.
- On wrap, line increments and wraps at V_LINES-1 to 0.
- LY_out equals line.

**Mode selection:**
- line ≥ V_ACTIVE → mode 1.
- Otherwise, dot < OAM_DOTS → mode 2.
- Mode 3 starts at dot OAM_DOTS. It ends the cycle after draw_done is sampled high, or when dot = OAM_DOTS+MAX_DRAW_DOTS, whichever comes first.
- Mode 0 then holds until the end of the line.
- draw_done is ignored outside mode 3.

**LCD disable (LCDC[7]=0):**
- dot, line and LY are forced to 0 and PPU_MODE to 0; no interrupts are raised.
- Registers remain writable.
- When LCDC[7] goes 0→1, the next cycle is dot 0, line 0, mode 2.

**Coincidence:** STAT[2] = (LY == LYC), evaluated every cycle against the current registered values.

**STAT line:** S = (STAT6 & coinc) | (STAT5 & mode2) | (STAT4 & mode1) | (STAT3 & mode0).
- IRQ_LCDC pulses only on a 0→1 transition of S.
- While S stays high, new sources do not retrigger the interrupt (blocking).

**V-blank:** IRQ_V_BLANK pulses on the single cycle where line becomes V_ACTIVE at dot 0.

## Timing
- **Writes:** take effect on the clk edge where WR is high. The new value is visible on the *_q outputs and in the STAT/coinc logic the following cycle.
- **Reads:** MMIO_DATA_in is registered. It is valid the cycle after RD and holds until the next RD. Reads of unowned addresses return 8'h00.
- **Counters and mode:** PPU_MODE, LY_out and DOT_out are registered and change on the same edge.
- **Interrupt latency:** each IRQ pulse appears one cycle after the condition becomes true.
- **LYC write vs. LY change:** a write to LYC in the same cycle LY changes compares the new LY with the new LYC on the next cycle. A resulting S rise yields exactly one IRQ_LCDC.
- **STAT writes:** a STAT write that raises S while a source is already true produces one pulse. A STAT write that keeps S high produces none.
- **Reset mid-frame:** reset returns everything to reset values on the next edge, with no pending pulses.

## Structure
- **ppu_pkg:** register address localparams (FF40–FF4B), the mode enum (HBLANK, VBLANK, OAM, DRAW), and the STAT bit indices.
- **ppu_mmio_regs (sub-module):** register bank, read mux and write decode.
- **Top level:** counters, mode FSM, coincidence and interrupt logic.

## Test plan
- **Reset then enable:** reset, then write LCDC=8'h80. Required: mode 2 for 80 cycles, then mode 3 for 289 cycles (draw_done held low), then mode 0 until dot 455. LY then becomes 1.
- **Full frame:** one frame = 154×456 cycles. Required: exactly one IRQ_V_BLANK, at line 144 dot 0; PPU_MODE=1 on lines 144–153; LY wraps from 153 to 0.
- **draw_done at dot 250:** required: PPU_MODE=0 from dot 251 of that line.
- **LYC interrupt:** LYC=10, STAT=8'h40. Required: one IRQ_LCDC at line 10 dot 0 (+1 cycle); STAT[2] reads 1 during line 10 and 0 during line 11.
- **STAT blocking:** STAT=8'h48 (coinc and mode 0), LYC=5. Required: a pulse at line 5 dot 0, and no pulse at entry to mode 0 on line 5. On line 6, a pulse at entry to mode 0.
- **Disable mid-line:** write LCDC=0 at line 50. Required: next cycle LY=0 and PPU_MODE=0, with no IRQs. A write of 8'hAB to SCX reads back 8'hAB; a write to LY does not change it.
